// File: rtl/accel_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accel_mem_pkg - shared constants, stall FSM encoding, address decode helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package accel_mem_pkg;

  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int          shift);
    return (addr - base) >> shift;
  endfunction

  // Below-base addresses wrap to huge offsets, so the explicit >= test is required.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input int          shift,
                                     input int          depth_log2);
    return (addr >= base) && ((word_index(addr, base, shift) >> depth_log2) == 64'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_mem_rdpipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accel_mem_rdpipe - valid+data delay line with synchronous flush
// Rev 1.0
// ----------------------------------------------------------------------------
module accel_mem_rdpipe #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_delay
      logic [DEPTH-1:0]                 valid_q, valid_d;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q,  data_d;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = DEPTH - 1; i > 0; i--) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        if (flush) begin
          valid_d = '0;
          data_d  = '0;
        end
      end

      always_ff @(posedge clk) begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/accel_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accel_mem_responder - Avalon-MM slave RAM with stalls, fixed read latency, counters
// Rev 1.0
// ----------------------------------------------------------------------------
module accel_mem_responder
  import accel_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h40000000),
  parameter int                    DEPTH_LOG2   = 10,
  parameter int                    READ_LATENCY = 2,
  parameter int                    WAIT_CYCLES  = 0
) (
  input  logic                    csi_clockreset_clk,
  input  logic                    csi_clockreset_reset_n,
  input  logic [ADDR_WIDTH-1:0]   avs_mem_address,
  input  logic                    avs_mem_read,
  input  logic                    avs_mem_write,
  input  logic [DATA_WIDTH-1:0]   avs_mem_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_mem_byteenable,
  output logic [DATA_WIDTH-1:0]   avs_mem_readdata,
  output logic                    avs_mem_readdatavalid,
  output logic                    avs_mem_waitrequest,
  output logic [31:0]             wr_count,
  output logic [31:0]             rd_count,
  output logic [15:0]             err_count
);

  localparam int                    BYTES     = DATA_WIDTH / 8;
  localparam int                    OFF_BITS  = $clog2(BYTES);
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]            WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] FILL      = {(DATA_WIDTH/32){FILL_WORD}};

  logic clk, rst_n;
  logic req, waitreq, accept, in_win, acc_wr, acc_rd;
  logic [DEPTH_LOG2-1:0] idx;

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [31:0]           wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign clk    = csi_clockreset_clk;
  assign rst_n  = csi_clockreset_reset_n;
  assign req    = avs_mem_read | avs_mem_write;
  assign in_win = in_window(64'(avs_mem_address), 64'(BASE_ADDR), OFF_BITS, DEPTH_LOG2);
  assign idx    = DEPTH_LOG2'(word_index(64'(avs_mem_address), 64'(BASE_ADDR), OFF_BITS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waitreq = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && WAIT_CYCLES != 0) begin
          waitreq = 1'b1;
          state_d = ST_STALL;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        // Dropping the request mid-stall abandons it without an accept.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < WAIT_LAST) begin
          waitreq = 1'b1;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign accept = rst_n & req & ~waitreq;
  assign acc_wr = accept & avs_mem_write;
  assign acc_rd = accept & avs_mem_read & ~avs_mem_write;

  always_comb begin
    rd_valid_d  = acc_rd;
    rd_data_d   = rd_data_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;
    if (acc_rd) rd_data_d = in_win ? mem_q[idx] : FILL;
    if (acc_wr && in_win) wr_count_d = wr_count_q + 32'd1;
    if (acc_rd && in_win) rd_count_d = rd_count_q + 32'd1;
    if (accept && ((avs_mem_read && avs_mem_write) || !in_win) && err_count_q != 16'hFFFF)
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Writes land on the accept edge, so a read accepted next cycle sees new data.
  always_ff @(posedge clk) begin
    if (acc_wr && in_win) begin
      for (int i = 0; i < BYTES; i++) begin
        if (avs_mem_byteenable[i]) mem_q[idx][i*8 +: 8] <= avs_mem_writedata[i*8 +: 8];
      end
    end
  end

  accel_mem_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY - 1)
  ) u_rdpipe (
    .clk       (clk),
    .flush     (~rst_n),
    .in_valid  (rd_valid_q),
    .in_data   (rd_data_q),
    .out_valid (avs_mem_readdatavalid),
    .out_data  (avs_mem_readdata)
  );

  assign avs_mem_waitrequest = waitreq;
  assign wr_count            = wr_count_q;
  assign rd_count            = rd_count_q;
  assign err_count           = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_accel_mem_responder - directed + random bench against a word-array reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_accel_mem_responder;

  localparam logic [31:0]  BASE = 32'h40000000;
  localparam logic [127:0] DEAD = {4{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  a_addr, b_addr;
  logic         a_rd, a_wr, b_rd, b_wr;
  logic [127:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [15:0]  a_be, b_be, a_errc, b_errc;
  logic         a_rvalid, b_rvalid, a_wait, b_wait;
  logic [31:0]  a_wrc, a_rdc, b_wrc, b_rdc;

  accel_mem_responder #(.WAIT_CYCLES(0)) dut (
    .csi_clockreset_clk(clk), .csi_clockreset_reset_n(rst_n),
    .avs_mem_address(a_addr), .avs_mem_read(a_rd), .avs_mem_write(a_wr),
    .avs_mem_writedata(a_wdata), .avs_mem_byteenable(a_be),
    .avs_mem_readdata(a_rdata), .avs_mem_readdatavalid(a_rvalid),
    .avs_mem_waitrequest(a_wait), .wr_count(a_wrc), .rd_count(a_rdc), .err_count(a_errc)
  );

  accel_mem_responder #(.WAIT_CYCLES(3)) dut_w (
    .csi_clockreset_clk(clk), .csi_clockreset_reset_n(rst_n),
    .avs_mem_address(b_addr), .avs_mem_read(b_rd), .avs_mem_write(b_wr),
    .avs_mem_writedata(b_wdata), .avs_mem_byteenable(b_be),
    .avs_mem_readdata(b_rdata), .avs_mem_readdatavalid(b_rvalid),
    .avs_mem_waitrequest(b_wait), .wr_count(b_wrc), .rd_count(b_rdc), .err_count(b_errc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model: word array, expected-response queue and counters.
  typedef struct {
    int           due;
    logic [127:0] data;
  } rsp_t;

  logic [127:0] mmem [1024];
  rsp_t         rq[$];
  int unsigned  m_wr = 0, m_rd = 0, m_err = 0;
  bit           mon_en = 1'b0;

  function automatic bit win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 32'd16 < 32'd1024);
  endfunction

  task automatic op(input bit r, input bit w, input logic [31:0] addr,
                    input logic [127:0] d, input logic [15:0] be);
    int   wi;
    rsp_t e;
    @(posedge clk); #1;
    a_rd = r; a_wr = w; a_addr = addr; a_wdata = d; a_be = be;
    wi = int'((addr - BASE) / 32'd16);
    if (w && win(addr)) begin
      for (int i = 0; i < 16; i++) if (be[i]) mmem[wi][i*8 +: 8] = d[i*8 +: 8];
      m_wr++;
    end
    if (r && !w) begin
      e.due  = cyc + 2;
      e.data = win(addr) ? mmem[wi] : DEAD;
      rq.push_back(e);
      if (win(addr)) m_rd++;
    end
    if ((r && w) || ((r || w) && !win(addr))) begin
      if (m_err < 65535) m_err++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a_rd = 1'b0; a_wr = 1'b0;
    end
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    chk({tag, "_wr_count"},  a_wrc,  128'(m_wr));
    chk({tag, "_rd_count"},  a_rdc,  128'(m_rd));
    chk({tag, "_err_count"}, a_errc, 128'(m_err));
  endtask

  // Hold a request on the stalled instance; waitrequest must be high exactly 3 cycles.
  task automatic stall_req(input string tag, input bit r, input bit w);
    @(posedge clk); #1;
    b_rd = r; b_wr = w;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(tag, b_wait, 128'(k < 3));
      @(posedge clk); #1;
    end
    b_rd = 1'b0; b_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("rvalid", a_rvalid, 1);
        chk("rdata", a_rdata, rq[0].data);
        void'(rq.pop_front());
      end else begin
        chk("rvalid_idle", a_rvalid, 0);
      end
    end
  end

  logic [31:0]  rnd_addr [12];
  logic [127:0] wd;

  initial begin
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_wr_count", a_wrc, 0);
    chk("rst_rd_count", a_rdc, 0);
    chk("rst_err_count", a_errc, 0);
    chk("rst_wait", a_wait, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;

    // Write then read back at word 0
    op(0, 1, BASE, 128'h0123456789ABCDEFFEDCBA9876543210, 16'hFFFF);
    op(1, 0, BASE, '0, '0);
    idle(4);
    chk_cnt("t1");

    // Partial byteenable
    op(0, 1, BASE + 32'h10, {128{1'b1}}, 16'hFFFF);
    op(0, 1, BASE + 32'h10, '0, 16'h00FF);
    op(1, 0, BASE + 32'h10, '0, '0);
    idle(4);

    // Back-to-back reads and read-after-write
    for (int k = 2; k < 6; k++) op(0, 1, BASE + 32'(k * 16), {4{$urandom()}}, 16'hFFFF);
    for (int k = 2; k < 6; k++) op(1, 0, BASE + 32'(k * 16), '0, '0);
    op(0, 1, BASE + 32'h60, {4{$urandom()}}, 16'hFFFF);
    op(1, 0, BASE + 32'h60, '0, '0);
    idle(4);
    chk_cnt("t3");

    // Window boundaries; 0x40004000 aliases word 0 if the decode truncates
    op(0, 1, BASE + 32'h3FF0, {4{$urandom()}}, 16'hFFFF);
    op(1, 0, BASE + 32'h3FF0, '0, '0);
    op(1, 0, 32'h3FFFFFF0, '0, '0);
    op(1, 0, 32'h40004000, '0, '0);
    op(0, 1, 32'h40004000, {4{$urandom()}}, 16'hFFFF);
    op(1, 0, BASE, '0, '0);
    idle(4);
    chk_cnt("t4");

    // Read and write together
    op(1, 1, BASE + 32'h10, {4{$urandom()}}, 16'hFFFF);
    op(1, 0, BASE + 32'h10, '0, '0);
    idle(4);
    chk_cnt("t5");

    // Random traffic over a few words plus out-of-window addresses
    for (int k = 0; k < 8; k++) begin
      rnd_addr[k] = BASE + 32'(k * 16);
      op(0, 1, rnd_addr[k], {4{$urandom()}}, 16'hFFFF);
    end
    rnd_addr[8] = BASE + 32'h3FF0; rnd_addr[9]  = 32'h3FFFFFF0;
    rnd_addr[10] = 32'h40004000;   rnd_addr[11] = 32'hFFFFFFF0;
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      op(kind inside {[3:6], 9}, kind inside {[7:9]}, rnd_addr[$urandom_range(0, 11)],
         {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()));
    end
    idle(4);
    chk_cnt("rand");

    // Stalled instance: write, read back, then an abandoned request
    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_addr = BASE + 32'h20; b_wdata = wd; b_be = 16'hFFFF;
    stall_req("stall_wr_wait", 0, 1);
    @(negedge clk);
    chk("stall_wr_count", b_wrc, 1);
    stall_req("stall_rd_wait", 1, 0);
    @(negedge clk);
    chk("stall_rvalid_early", b_rvalid, 0);
    @(negedge clk);
    chk("stall_rvalid", b_rvalid, 1);
    chk("stall_rdata", b_rdata, wd);
    @(posedge clk); #1;
    b_rd = 1'b1;
    @(negedge clk);
    chk("drop_wait", b_wait, 1);
    @(posedge clk); #1;
    b_rd = 1'b0;
    @(negedge clk);
    chk("noreq_wait", b_wait, 0);
    stall_req("restall_wait", 1, 0);
    repeat (2) @(negedge clk);
    chk("restall_rdata", b_rdata, wd);
    chk("stall_rd_count", b_rdc, 2);
    chk("stall_err_count", b_errc, 0);

    // Reset with a read in flight
    op(1, 0, BASE, '0, '0);
    @(posedge clk); #1;
    a_rd = 1'b0; rst_n = 1'b0;
    rq.delete();
    m_wr = 0; m_rd = 0; m_err = 0;
    repeat (2) @(posedge clk);
    chk_cnt("t6_rst");
    chk("t6_rdata", a_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(1, 0, BASE, '0, '0);
    idle(5);
    chk_cnt("t6_after");
    chk("rq_drained", 128'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
